// File: rtl/fib_checker.sv
// fib_checker: verifies an incoming stream is the Fibonacci sequence mod 2^WIDTH,
// reporting lock, first-mismatch index/expectation, and carry-out wrap.
`default_nettype none

module fib_checker #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               locked,
  output logic               error,
  output logic [COUNT_W-1:0] error_index,
  output logic [WIDTH-1:0]   expected,
  output logic [COUNT_W-1:0] term_count,
  output logic               wrapped
);

  typedef enum logic [1:0] {
    WAIT0 = 2'd0,
    WAIT1 = 2'd1,
    TRACK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  state_t             state;
  logic [WIDTH-1:0]   prev;
  logic [WIDTH-1:0]   cur;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   next_expected;
  logic [COUNT_W-1:0] count_next;

  // Bit WIDTH of the sum is the carry that flags arithmetic wrap.
  assign sum           = {1'b0, prev} + {1'b0, cur};
  assign next_expected = cur + in_data;
  assign count_next    = (term_count == COUNT_MAX) ? term_count : term_count + COUNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state       <= WAIT0;
      prev        <= '0;
      cur         <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      wrapped     <= 1'b0;
      error_index <= '0;
      expected    <= '0;
      term_count  <= '0;
    end else if (in_valid) begin
      case (state)
        WAIT0: begin
          if (in_data == '0) begin
            state      <= WAIT1;
            term_count <= count_next;
            expected   <= WIDTH'(1);
          end else begin
            state       <= FAIL;
            error       <= 1'b1;
            locked      <= 1'b0;
            error_index <= term_count;
          end
        end
        WAIT1: begin
          if (in_data == WIDTH'(1)) begin
            state      <= TRACK;
            prev       <= '0;
            cur        <= WIDTH'(1);
            term_count <= count_next;
            expected   <= WIDTH'(1);
            locked     <= 1'b1;
          end else begin
            state       <= FAIL;
            error       <= 1'b1;
            locked      <= 1'b0;
            error_index <= term_count;
          end
        end
        TRACK: begin
          if (in_data == sum[WIDTH-1:0]) begin
            prev       <= cur;
            cur        <= in_data;
            term_count <= count_next;
            expected   <= next_expected;
            if (sum[WIDTH]) wrapped <= 1'b1;
          end else begin
            // expected already holds prev+cur, so it freezes at the failed value
            state       <= FAIL;
            error       <= 1'b1;
            locked      <= 1'b0;
            error_index <= term_count;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fib_checker.sv
// Scoreboard bench for fib_checker: a behavioural model pushes the expected
// output snapshot per cycle; each scenario pops and compares after the edge.
`default_nettype none

module tb_fib_checker;

  localparam int WIDTH   = 32;
  localparam int COUNT_W = 8;

  typedef logic [3+2*COUNT_W+WIDTH-1:0] snap_t;

  logic               clock;
  logic               reset;
  logic               clear;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               locked;
  logic               error;
  logic [COUNT_W-1:0] error_index;
  logic [WIDTH-1:0]   expected;
  logic [COUNT_W-1:0] term_count;
  logic               wrapped;

  fib_checker #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .error(error), .error_index(error_index), .expected(expected),
    .term_count(term_count), .wrapped(wrapped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  snap_t outs;
  assign outs = {locked, error, wrapped, error_index, expected, term_count};

  snap_t sb[$];
  snap_t got, want;
  int checks = 0;
  int errors = 0;

  // Reference model state
  int                 m_st;
  logic [WIDTH-1:0]   m_prev, m_cur, m_exp;
  logic [COUNT_W-1:0] m_cnt, m_eidx;
  logic               m_lock, m_err, m_wrap;

  task automatic model_fail();
    m_st = 3; m_err = 1'b1; m_lock = 1'b0; m_eidx = m_cnt;
  endtask

  task automatic model_step(input logic v, input logic [WIDTH-1:0] d, input logic rst);
    longint unsigned t;
    if (rst) begin
      m_st = 0; m_prev = '0; m_cur = '0; m_exp = '0; m_cnt = '0; m_eidx = '0;
      m_lock = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
    end else if (v && m_st != 3) begin
      if (m_st == 0) begin
        if (d == 0) begin m_st = 1; m_cnt = 1; m_exp = 1; end
        else model_fail();
      end else if (m_st == 1) begin
        if (d == 1) begin m_st = 2; m_prev = 0; m_cur = 1; m_cnt = 2; m_exp = 1; m_lock = 1'b1; end
        else model_fail();
      end else begin
        t = longint'(m_prev) + longint'(m_cur);
        if (d == WIDTH'(t)) begin
          if (t >= (64'd1 << WIDTH)) m_wrap = 1'b1;
          m_exp  = WIDTH'(longint'(m_cur) + longint'(d));
          m_prev = m_cur;
          m_cur  = d;
          if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end else model_fail();
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic c, input logic r);
    in_valid = v; in_data = d; clear = c; reset = r;
    model_step(v, d, c | r);
    sb.push_back({m_lock, m_err, m_wrap, m_eidx, m_exp, m_cnt});
    @(posedge clock);
    #1;
    in_valid = 1'b0; in_data = '0; clear = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 32'd5, 1'b0, 1'b1);
    got = outs; want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_sb got %h want %h", got, want); end
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_values got %h want 0", outs); end
  endtask

  task automatic test_normal();
    logic [WIDTH-1:0] seq [7] = '{0, 1, 1, 2, 3, 5, 8};
    cycle(1'b0, '0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, seq[i], 1'b0, 1'b0);
      got = outs; want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL normal[%0d] got %h want %h", i, got, want); end
      if (i == 1) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL normal_lock got %b want 1", locked); end
      end
    end
    checks++;
    if (term_count !== 8'd7 || expected !== 32'd13 || error !== 1'b0 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL normal_final got cnt=%0d exp=%0d err=%b wrap=%b want 7 13 0 0",
               term_count, expected, error, wrapped);
    end
  endtask

  task automatic test_mismatch();
    logic [WIDTH-1:0] seq [6] = '{0, 1, 1, 2, 4, 7};
    cycle(1'b0, '0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, seq[i], 1'b0, 1'b0);
      got = outs; want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL mismatch[%0d] got %h want %h", i, got, want); end
      checks++;
      if (i >= 4 && (error !== 1'b1 || error_index !== 8'd4 || expected !== 32'd3 ||
                     term_count !== 8'd4 || locked !== 1'b0)) begin
        errors++;
        $display("FAIL mismatch_fields[%0d] got err=%b idx=%0d exp=%0d cnt=%0d lock=%b want 1 4 3 4 0",
                 i, error, error_index, expected, term_count, locked);
      end
    end
  endtask

  task automatic test_bad_start();
    cycle(1'b0, '0, 1'b0, 1'b1); void'(sb.pop_front());
    cycle(1'b1, 32'd1, 1'b0, 1'b0);
    got = outs; want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL bad_start_sb got %h want %h", got, want); end
    checks++;
    if (error !== 1'b1 || error_index !== 8'd0 || expected !== 32'd0 || term_count !== 8'd0) begin
      errors++;
      $display("FAIL bad_start got err=%b idx=%0d exp=%0d cnt=%0d want 1 0 0 0",
               error, error_index, expected, term_count);
    end
  endtask

  task automatic test_gaps();
    logic             vs [7] = '{1, 0, 1, 0, 0, 1, 1};
    logic [WIDTH-1:0] ds [7] = '{0, 9, 1, 9, 9, 1, 2};
    cycle(1'b0, '0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 7; i++) begin
      cycle(vs[i], ds[i], 1'b0, 1'b0);
      got = outs; want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL gaps[%0d] got %h want %h", i, got, want); end
    end
    checks++;
    if (term_count !== 8'd4 || expected !== 32'd3 || locked !== 1'b1) begin
      errors++;
      $display("FAIL gaps_final got cnt=%0d exp=%0d lock=%b want 4 3 1", term_count, expected, locked);
    end
  endtask

  task automatic test_wrap();
    longint unsigned a = 0, b = 1, n;
    cycle(1'b0, '0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 49; i++) begin
      if (i == 48) begin
        checks++;
        if (WIDTH'(a) !== 32'd512559680) begin
          errors++; $display("FAIL wrap_stim got %0d want 512559680", WIDTH'(a));
        end
      end
      cycle(1'b1, WIDTH'(a), 1'b0, 1'b0);
      got = outs; want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL wrap[%0d] got %h want %h", i, got, want); end
      if (i == 47) begin
        checks++;
        if (wrapped !== 1'b0) begin errors++; $display("FAIL wrap_early got %b want 0", wrapped); end
      end
      n = a + b; a = b; b = n;
    end
    checks++;
    if (wrapped !== 1'b1 || error !== 1'b0 || term_count !== 8'd49) begin
      errors++;
      $display("FAIL wrap_final got wrap=%b err=%b cnt=%0d want 1 0 49", wrapped, error, term_count);
    end
  endtask

  task automatic test_restart();
    logic [WIDTH-1:0] seq [5] = '{0, 1, 1, 2, 3};
    cycle(1'b0, '0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, seq[i], 1'b0, 1'b0); void'(sb.pop_front());
    end
    cycle(1'b1, 32'd5, 1'b1, 1'b0);
    got = outs; want = sb.pop_front(); checks++;
    if (got !== want || got !== '0) begin errors++; $display("FAIL restart_clear got %h want 0", got); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, seq[i], 1'b0, 1'b0);
      got = outs; want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL restart[%0d] got %h want %h", i, got, want); end
    end
    checks++;
    if (term_count !== 8'd3 || locked !== 1'b1) begin
      errors++; $display("FAIL restart_fresh got cnt=%0d lock=%b want 3 1", term_count, locked);
    end
    cycle(1'b1, 32'd7, 1'b0, 1'b0);
    got = outs; want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL restart_fail got %h want %h", got, want); end
    cycle(1'b1, 32'd0, 1'b0, 1'b1);
    got = outs; want = sb.pop_front(); checks++;
    if (got !== want || got !== '0) begin errors++; $display("FAIL restart_reset got %h want 0", got); end
  endtask

  // Runs past counter saturation, then plants a mismatch at the saturated index.
  task automatic test_back_to_back();
    longint unsigned a = 0, b = 1, n;
    cycle(1'b0, '0, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 260; i++) begin
      cycle(1'b1, WIDTH'(a), 1'b0, 1'b0);
      got = outs; want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL b2b[%0d] got %h want %h", i, got, want); end
      n = a + b; a = b; b = n;
    end
    checks++;
    if (term_count !== 8'hFF || locked !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL sat_count got cnt=%0d lock=%b err=%b want 255 1 0", term_count, locked, error);
    end
    cycle(1'b1, WIDTH'(a) + 32'd1, 1'b0, 1'b0);
    got = outs; want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL sat_mismatch got %h want %h", got, want); end
    checks++;
    if (error_index !== 8'hFF || error !== 1'b1 || expected !== WIDTH'(a)) begin
      errors++;
      $display("FAIL sat_index got idx=%0d err=%b exp=%h want 255 1 %h",
               error_index, error, expected, WIDTH'(a));
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_normal();
    test_mismatch();
    test_bad_start();
    test_gaps();
    test_wrap();
    test_restart();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
